// File: rtl/dec_mult_norm_seq_if.sv
// Operand/multiplier handshake bundle for the BCD operand normalizer.
// master = requester + multiplier side, slave = the normalizer itself.
interface dec_mult_norm_seq_if #(
   parameter int NDIG = 7,
   parameter int EW   = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [EW-1:0]     E1, E2;
   logic [4*NDIG-1:0] M1, M2;
   logic              mul_start;
   logic [EW-1:0]     mul_E1, mul_E2;
   logic [4*NDIG-1:0] mul_M1, mul_M2;
   logic              mul_done;
   logic              op_done;
   logic              op_err;
   logic              busy;
   logic [2:0]        sh1, sh2;

   modport master (
      output in_valid, E1, E2, M1, M2, mul_done,
      input  in_ready, mul_start, mul_E1, mul_E2, mul_M1, mul_M2,
             op_done, op_err, busy, sh1, sh2
   );

   modport slave (
      input  in_valid, E1, E2, M1, M2, mul_done,
      output in_ready, mul_start, mul_E1, mul_E2, mul_M1, mul_M2,
             op_done, op_err, busy, sh1, sh2
   );
endinterface

// File: rtl/dec_mult_norm_seq.sv
// Strips leading zero BCD digits from two operands (bounded by exponent and
// MAXSH), issues one start to the multiplier and waits for done or timeout.
module dec_mult_norm_seq #(
   parameter int NDIG  = 7,
   parameter int EW    = 8,
   parameter int MAXSH = 6,
   parameter int TMO   = 64
) (
   input logic clk,
   input logic rst_n,
   dec_mult_norm_seq_if.slave bus
);
   localparam int MW = 4 * NDIG;
   localparam int CW = (TMO > 1) ? $clog2(TMO) : 1;

   typedef enum logic [1:0] {IDLE, NORM, ISSUE, WAIT} state_t;

   state_t              state_q, state_d;
   logic [1:0][MW-1:0]  m_q;
   logic [1:0][EW-1:0]  e_q;
   logic [1:0][2:0]     sh_q;
   logic [1:0]          shf;
   logic [CW-1:0]       cnt_q;
   logic                done_q, err_q;
   logic                accept, tmo_hit;

   assign accept  = (state_q == IDLE) && bus.in_valid;
   assign tmo_hit = (cnt_q == CW'(TMO - 1));

   // Each operand decides independently; both may shift in the same cycle.
   always_comb begin
      shf = '0;
      for (int i = 0; i < 2; i++)
         shf[i] = (m_q[i][MW-1 -: 4] == 4'd0) && (e_q[i] != '0) &&
                  (sh_q[i] < 3'(MAXSH));
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.in_valid) state_d = NORM;
         NORM:    if (shf == 2'b00) state_d = ISSUE;
         ISSUE:   state_d = WAIT;
         WAIT:    if (bus.mul_done || tmo_hit) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q  <= '0;
         e_q  <= '0;
         sh_q <= '0;
      end else if (accept) begin
         m_q  <= {bus.M2, bus.M1};
         e_q  <= {bus.E2, bus.E1};
         sh_q <= '0;
      end else if (state_q == NORM) begin
         for (int i = 0; i < 2; i++) begin
            if (shf[i]) begin
               m_q[i]  <= {m_q[i][MW-5:0], 4'd0};
               e_q[i]  <= e_q[i] - EW'(1);
               sh_q[i] <= sh_q[i] + 3'd1;
            end
         end
      end
   end

   // Counter is zeroed in ISSUE so it reads 0 on the first WAIT cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         if (state_q == ISSUE)     cnt_q <= '0;
         else if (state_q == WAIT) cnt_q <= cnt_q + CW'(1);
         done_q <= (state_q == WAIT) && bus.mul_done;
         err_q  <= (state_q == WAIT) && !bus.mul_done && tmo_hit;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.mul_start = (state_q == ISSUE);
   assign bus.mul_M1    = m_q[0];
   assign bus.mul_M2    = m_q[1];
   assign bus.mul_E1    = e_q[0];
   assign bus.mul_E2    = e_q[1];
   assign bus.sh1       = sh_q[0];
   assign bus.sh2       = sh_q[1];
   assign bus.op_done   = done_q;
   assign bus.op_err    = err_q;
endmodule

// File: tb/tb_dec_mult_norm_seq.sv
// Bench for dec_mult_norm_seq: vector table + scoreboard queue, plus
// sequences for timeout, late done, ignored done, held valid and reset.
module tb_dec_mult_norm_seq;
   localparam int NDIG = 7, EW = 8, MAXSH = 6, TMO = 64, NV = 10;

   typedef struct {
      logic [27:0] m1, m2;
      logic [7:0]  e1, e2;
      logic [27:0] xm1, xm2;
      logic [7:0]  xe1, xe2;
      logic [2:0]  xs1, xs2;
      int          norm;
   } vec_t;

   logic clk = 0, rst_n = 0;
   int   total = 0, bad = 0;
   vec_t sbq[$];
   vec_t tbl[NV];

   dec_mult_norm_seq_if #(.NDIG(NDIG), .EW(EW)) mif();
   dec_mult_norm_seq #(.NDIG(NDIG), .EW(EW), .MAXSH(MAXSH), .TMO(TMO))
      dut (.clk(clk), .rst_n(rst_n), .bus(mif.slave));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [27:0] m1, input logic [7:0] e1,
                               input logic [27:0] m2, input logic [7:0] e2);
      vec_t v;
      v = '{default: '0};
      v.m1 = m1; v.e1 = e1; v.m2 = m2; v.e2 = e2;
      return v;
   endfunction

   // Closed-form reference: k = min(leading zero digits, E, MAXSH).
   function automatic int kof(input logic [27:0] m, input logic [7:0] e);
      int lz = 0;
      for (int d = 6; d >= 0; d--) begin
         if (m[4*d +: 4] != 4'd0) break;
         lz++;
      end
      if (lz > int'(e)) lz = int'(e);
      if (lz > MAXSH) lz = MAXSH;
      return lz;
   endfunction

   function automatic vec_t model(input vec_t v);
      int k1, k2;
      k1 = kof(v.m1, v.e1);
      k2 = kof(v.m2, v.e2);
      v.xm1 = v.m1 << (4 * k1); v.xe1 = v.e1 - 8'(k1); v.xs1 = 3'(k1);
      v.xm2 = v.m2 << (4 * k2); v.xe2 = v.e2 - 8'(k2); v.xs2 = 3'(k2);
      v.norm = ((k1 > k2) ? k1 : k2) + 1;
      return v;
   endfunction

   // dly>0: mul_done on the dly-th cycle after mul_start; dly<0: let it time out.
   // Returns at the negedge where op_done/op_err is visible.
   task automatic do_op(input vec_t v, input bit chain, input int dly,
                        input bit hold, input bit nd);
      int norm; bit got; vec_t x; int cnt;
      if (!chain) @(negedge clk);
      chk("accept_ready", mif.in_ready, 1);
      sbq.push_back(v);
      mif.in_valid = 1; mif.M1 = v.m1; mif.E1 = v.e1; mif.M2 = v.m2; mif.E2 = v.e2;
      @(posedge clk); #1;
      if (hold) begin
         mif.M1 = ~v.m1; mif.E1 = ~v.e1; mif.M2 = ~v.m2; mif.E2 = ~v.e2;
      end else mif.in_valid = 0;
      norm = 0; got = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         mif.mul_done = 0;
         if (mif.mul_start) begin got = 1; break; end
         if (norm == 0) begin
            chk("busy_norm", mif.busy, 1);
            chk("ready_low", mif.in_ready, 0);
            chk("no_stray_pulse", {31'd0, mif.op_done | mif.op_err}, 0);
         end
         if (nd && norm == 1) mif.mul_done = 1;
         norm++;
      end
      mif.in_valid = 0;
      if (!got) begin chk("start_seen", 0, 1); return; end
      x = sbq.pop_front();
      chk("norm_cycles", norm, x.norm);
      chk("mul_M1", mif.mul_M1, x.xm1);
      chk("mul_E1", mif.mul_E1, x.xe1);
      chk("sh1", mif.sh1, x.xs1);
      chk("mul_M2", mif.mul_M2, x.xm2);
      chk("mul_E2", mif.mul_E2, x.xe2);
      chk("sh2", mif.sh2, x.xs2);
      if (dly < 0) begin
         cnt = 0;
         for (int i = 0; i < 100; i++) begin
            @(negedge clk); cnt++;
            if (mif.op_err) break;
         end
         chk("tmo_cycles", cnt, 65);
         chk("tmo_no_done", mif.op_done, 0);
         chk("tmo_ready", mif.in_ready, 1);
         @(negedge clk);
         chk("err_one_cycle", mif.op_err, 0);
      end else begin
         for (int i = 1; i <= dly; i++) begin
            @(negedge clk);
            if (i == 1) chk("start_1cyc", mif.mul_start, 0);
         end
         chk("wait_busy", mif.busy, 1);
         chk("wait_no_done", mif.op_done, 0);
         chk("mregs_stable", mif.mul_M1, x.xm1);
         mif.mul_done = 1;
         @(negedge clk);
         mif.mul_done = 0;
         chk("op_done", mif.op_done, 1);
         chk("no_err", mif.op_err, 0);
         chk("done_ready", mif.in_ready, 1);
      end
   endtask

   initial begin
      mif.in_valid = 0; mif.mul_done = 0;
      mif.M1 = '0; mif.M2 = '0; mif.E1 = '0; mif.E2 = '0;

      tbl[0] = mk(28'h0001234, 8'd10, 28'h1000000, 8'd5);
      tbl[0].xm1 = 28'h1234000; tbl[0].xe1 = 7; tbl[0].xs1 = 3;
      tbl[0].xm2 = 28'h1000000; tbl[0].xe2 = 5; tbl[0].xs2 = 0; tbl[0].norm = 4;
      tbl[1] = mk(28'h0000056, 8'd2, 28'h1000000, 8'd3);
      tbl[1].xm1 = 28'h0005600; tbl[1].xe1 = 0; tbl[1].xs1 = 2;
      tbl[1].xm2 = 28'h1000000; tbl[1].xe2 = 3; tbl[1].xs2 = 0; tbl[1].norm = 3;
      tbl[2] = mk(28'h0000000, 8'd9, 28'h0000001, 8'd20);
      tbl[2].xm1 = 28'h0000000; tbl[2].xe1 = 3; tbl[2].xs1 = 6;
      tbl[2].xm2 = 28'h1000000; tbl[2].xe2 = 14; tbl[2].xs2 = 6; tbl[2].norm = 7;
      tbl[3] = mk(28'h0000100, 8'd0, 28'h0120000, 8'd1);
      tbl[3].xm1 = 28'h0000100; tbl[3].xe1 = 0; tbl[3].xs1 = 0;
      tbl[3].xm2 = 28'h1200000; tbl[3].xe2 = 0; tbl[3].xs2 = 1; tbl[3].norm = 2;
      for (int i = 4; i < NV; i++) begin
         logic [27:0] a, b;
         a = 28'($urandom) >> (4 * $urandom_range(0, 7));
         b = 28'($urandom) >> (4 * $urandom_range(0, 7));
         tbl[i] = model(mk(a, 8'($urandom_range(0, 8)), b, 8'($urandom_range(0, 8))));
      end

      repeat (3) @(negedge clk);
      chk("rst_ready", mif.in_ready, 1);
      chk("rst_busy", mif.busy, 0);
      chk("rst_start", mif.mul_start, 0);
      chk("rst_mregs", {4'd0, mif.mul_M1 | mif.mul_M2}, 0);
      chk("rst_sh", {26'd0, mif.sh1, mif.sh2}, 0);
      rst_n = 1;

      // First accept right after reset release, then chained/back-to-back ops.
      for (int i = 0; i < NV; i++)
         do_op(tbl[i], (i == 0) || (i % 2 == 1), 1 + i % 3, 0, 0);

      do_op(tbl[0], 0, 2, 1, 0);   // in_valid held with changing data while busy
      do_op(tbl[2], 0, 5, 0, 1);   // mul_done during NORM must be ignored
      do_op(tbl[1], 1, 64, 0, 0);  // mul_done in the last timeout cycle
      do_op(tbl[3], 0, -1, 0, 0);  // timeout

      // Reset in the middle of WAIT.
      @(negedge clk);
      mif.in_valid = 1; mif.M1 = tbl[0].m1; mif.E1 = tbl[0].e1;
      mif.M2 = tbl[0].m2; mif.E2 = tbl[0].e2;
      @(negedge clk);
      mif.in_valid = 0;
      begin
         bit got = 0;
         for (int i = 0; i < 40; i++) begin
            if (mif.mul_start) begin got = 1; break; end
            @(negedge clk);
         end
         chk("rst_seq_start", got, 1);
      end
      repeat (3) @(negedge clk);
      rst_n = 0; #1;
      chk("arst_busy", mif.busy, 0);
      chk("arst_ready", mif.in_ready, 1);
      chk("arst_mM1", mif.mul_M1, 0);
      chk("arst_mE2", mif.mul_E2, 0);
      chk("arst_sh1", mif.sh1, 0);
      @(negedge clk); mif.mul_done = 1;
      @(negedge clk); mif.mul_done = 0;
      chk("arst_no_done", {30'd0, mif.op_done, mif.op_err}, 0);
      rst_n = 1;
      do_op(tbl[5], 1, 3, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/dec_mult_norm_seq.md
DEC_MULT_NORM_SEQ -- requirements
Module: dec_mult_norm_seq

Interface
REQ-001 SHALL have parameter NDIG, default 7, the number of BCD mantissa digits; the mantissa width is 4*NDIG.
REQ-002 SHALL have parameter EW, default 8, the exponent width.
REQ-003 SHALL have parameter MAXSH, default 6, the maximum number of leading-zero digits removed per operand.
REQ-004 SHALL have parameter TMO, default 64, the number of WAIT cycles without mul_done before an error is raised.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all flops are rising-edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port in_valid, input, 1 bit: an operand pair is offered.
REQ-008 SHALL have port in_ready, output, 1 bit: the block accepts an operand pair; high only in IDLE.
REQ-009 SHALL have ports E1 and E2, input, EW bits each: the operand exponents.
REQ-010 SHALL have ports M1 and M2, input, 4*NDIG bits each: the BCD operand mantissas, most significant digit at the MSBs.
REQ-011 SHALL have port mul_start, output, 1 bit: a one-cycle start pulse to the multiplier datapath.
REQ-012 SHALL have ports mul_E1 and mul_E2, output, EW bits each: the registered normalized exponents.
REQ-013 SHALL have ports mul_M1 and mul_M2, output, 4*NDIG bits each: the registered normalized mantissas.
REQ-014 SHALL have port mul_done, input, 1 bit: a completion pulse from the multiplier.
REQ-015 SHALL have port op_done, output, 1 bit: a one-cycle pulse when the operation completes normally.
REQ-016 SHALL have port op_err, output, 1 bit: a one-cycle pulse when the multiplier times out.
REQ-017 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-018 SHALL have ports sh1 and sh2, output, 3 bits each: the count of digits shifted for each operand in the current operation.

Function
REQ-019 SHALL implement the states IDLE, NORM, ISSUE and WAIT.
REQ-020 SHALL, in IDLE on a rising edge where in_valid and in_ready are both high, load E1, E2, M1 and M2 into the mul_* registers, clear sh1 and sh2, and enter NORM.
REQ-021 SHALL, in NORM, treat operand i as shiftable when its top digit is 0, its exponent is greater than 0 and its shi is less than MAXSH.
REQ-022 SHALL, for each shiftable operand on every NORM cycle, shift the mantissa left by 4 with 0 filled in, decrement the exponent by 1 and increment shi by 1.
REQ-023 SHALL process both operands independently within the same cycle.
REQ-024 SHALL go from NORM to ISSUE on the first cycle in which neither operand is shiftable; nothing is shifted in that cycle.
REQ-025 SHALL therefore hold NORM for exactly max(k1,k2)+1 cycles, where ki = min(leading zero digits of Mi, Ei, MAXSH).
REQ-026 SHALL treat an all-zero mantissa as having NDIG leading zero digits, so it is capped at MAXSH shifts and its exponent stops at Ei-min(Ei,MAXSH).
REQ-027 SHALL never underflow an exponent: once Ei reaches 0, shifting of that operand stops.
REQ-028 SHALL, in ISSUE, drive mul_start high for exactly 1 cycle and then enter WAIT.
REQ-029 SHALL hold the mul_* registers stable from ISSUE until the next accept.
REQ-030 SHALL, in WAIT, keep a timeout counter that is cleared on entering WAIT and incremented every WAIT cycle.
REQ-031 SHALL, on mul_done high in WAIT, pulse op_done on the next cycle and return to IDLE.
REQ-032 SHALL, when the timeout counter reaches TMO-1 with mul_done low, pulse op_err on the next cycle and return to IDLE.
REQ-033 SHALL give mul_done priority over the timeout when both occur in the same cycle: op_done pulses and op_err does not.
REQ-034 SHALL ignore mul_done in every state other than WAIT.
REQ-035 SHALL hold in_ready low in NORM, ISSUE and WAIT; an in_valid held high during those states SHALL NOT be captured until the block is back in IDLE.
REQ-036 SHALL allow an accept in the IDLE cycle directly following op_done or op_err, so back-to-back operations are possible.
REQ-037 SHALL drive op_done and op_err from registers, and SHALL never assert both in the same cycle.

Reset
REQ-038 SHALL, while rst_n is low and regardless of clk, force the state to IDLE.
REQ-039 SHALL, while rst_n is low, force mul_start, op_done, op_err and busy to 0 and in_ready to 1.
REQ-040 SHALL, while rst_n is low, force mul_E1, mul_E2, mul_M1, mul_M2, sh1, sh2 and the timeout counter to 0.
REQ-041 SHALL, when rst_n is asserted in the middle of an operation, abandon that operation with no op_done or op_err pulse.
REQ-042 SHALL leave reset cleanly: after rst_n rises, the first accept is possible on the first rising clk edge.

Verification
REQ-043 SHALL cover accept of M1=0x0001234, E1=10, M2=0x1000000, E2=5 -> 4 NORM cycles, then mul_M1=0x1234000, mul_E1=7, sh1=3, mul_M2=0x1000000, mul_E2=5, sh2=0, then one mul_start pulse.
REQ-044 SHALL cover the exponent limit, M1=0x0000056 with E1=2 -> mul_M1=0x0005600, mul_E1=0, sh1=2, with 3 NORM cycles.
REQ-045 SHALL cover the zero mantissa, M1=0 with E1=9 and M2=0x0000001 with E2=20 -> mul_E1=3, sh1=6, mul_M2=0x1000000, mul_E2=14, sh2=6.
REQ-046 SHALL cover the timeout, no mul_done after ISSUE with TMO=64 -> op_err pulses once 65 cycles after mul_start, then in_ready=1.
REQ-047 SHALL cover mul_done in the last timeout cycle -> op_done=1 and op_err=0.
REQ-048 SHALL cover mul_done pulsed during NORM -> it is ignored and the block still waits in WAIT.
REQ-049 SHALL cover rst_n pulsed low in WAIT -> outputs take reset values immediately and no op_done follows.
